// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Stretches a single-cycle trigger into a fixed-length output
//                pulse, then enforces a hold-off gap before the next trigger
//                is accepted. Ignored triggers raise a one-cycle flag and
//                accepted ones are counted.
//
//  Ports
//    clk           in   system clock, rising edge
//    rst           in   asynchronous reset, active low
//    pulse_in      in   trigger, synchronous to clk, any width
//    retrigger_en  in   1 = trigger while high restarts the width count
//    pulse_out     out  stretched pulse (registered)
//    busy          out  high while the pulse or the hold-off runs (registered)
//    dropped       out  one-cycle flag, a trigger was ignored (registered)
//    pulse_count   out  accepted (non-retrigger) triggers, wraps
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
    parameter int WIDTH_CYCLES   = 25000000,
    parameter int HOLDOFF_CYCLES = 5000000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             retrigger_en,
    output logic             pulse_out,
    output logic             busy,
    output logic             dropped,
    output logic [CNT_W-1:0] pulse_count
);

    // One down-counter serves both the pulse and the hold-off phase.
    localparam int c_MAX_CYCLES = (WIDTH_CYCLES > HOLDOFF_CYCLES) ? WIDTH_CYCLES : HOLDOFF_CYCLES;
    localparam int c_CNT_BITS   = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_BITS-1:0] c_WIDTH_LOAD = c_CNT_BITS'(WIDTH_CYCLES);
    localparam logic [c_CNT_BITS-1:0] c_HOLD_LOAD  = c_CNT_BITS'(HOLDOFF_CYCLES);
    localparam logic [c_CNT_BITS-1:0] c_ONE        = c_CNT_BITS'(1);
    localparam logic [CNT_W-1:0]      c_CNT_INC    = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HIGH    = 2'd1;
    localparam logic [1:0] c_ST_HOLDOFF = 2'd2;

    generate
        if (WIDTH_CYCLES < 1 || HOLDOFF_CYCLES < 0) begin : g_param_check
            $error("pulse_stretcher: WIDTH_CYCLES must be >= 1 and HOLDOFF_CYCLES >= 0");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [c_CNT_BITS-1:0] r_cnt;

    logic w_last;
    logic w_retrig;

    // Counter value 1 marks the final edge of the current phase.
    assign w_last   = (r_cnt == c_ONE);
    assign w_retrig = pulse_in & retrigger_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            dropped     <= 1'b0;
            pulse_count <= '0;
        end else begin
            dropped <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (pulse_in) begin
                        r_state     <= c_ST_HIGH;
                        r_cnt       <= c_WIDTH_LOAD;
                        pulse_out   <= 1'b1;
                        busy        <= 1'b1;
                        pulse_count <= pulse_count + c_CNT_INC;
                    end
                end

                c_ST_HIGH: begin
                    // Non-retrigger triggers while high are ignored; the
                    // zero-hold-off case below may turn one into an accept.
                    dropped <= pulse_in & ~retrigger_en;
                    if (w_retrig) begin
                        r_cnt <= c_WIDTH_LOAD;
                    end else if (w_last) begin
                        if (HOLDOFF_CYCLES == 0) begin
                            // Without a hold-off the final high edge is the
                            // idle boundary, so a trigger here starts a fresh
                            // pulse back-to-back and busy never drops.
                            if (pulse_in) begin
                                r_cnt       <= c_WIDTH_LOAD;
                                dropped     <= 1'b0;
                                pulse_count <= pulse_count + c_CNT_INC;
                            end else begin
                                r_state   <= c_ST_IDLE;
                                pulse_out <= 1'b0;
                                busy      <= 1'b0;
                            end
                        end else begin
                            r_state   <= c_ST_HOLDOFF;
                            r_cnt     <= c_HOLD_LOAD;
                            pulse_out <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end

                c_ST_HOLDOFF: begin
                    // Every trigger in hold-off is refused, the last edge too.
                    dropped <= pulse_in;
                    if (w_last) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end

                default: begin
                    r_state   <= c_ST_IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
